// File: rtl/acl_spi_responder_if.sv
// SPI pin bundle between an ADXL362-style master and the acl_spi_responder slave.
// miso_oe qualifies miso for an external pad tristate.
interface acl_spi_responder_if;
  logic sclk;
  logic mosi;
  logic cs_n;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output mosi, output cs_n, input miso, input miso_oe);
  modport slave  (input sclk, input mosi, input cs_n, output miso, output miso_oe);
endinterface

// File: rtl/acl_spi_responder.sv
// ADXL362 register-interface emulator: oversampled mode-0 SPI slave with read/write/burst.
// Optional macro ACL_RESP_SNAPSHOT_EN serves data reads from x/y/z shadows taken at cs_n fall.
module acl_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  PARTID      = 8'hF2
) (
  input  logic                      ClkPort,
  input  logic                      Reset_n,
  acl_spi_responder_if.slave        spi,
  input  logic [11:0]               x_data,
  input  logic [11:0]               y_data,
  input  logic [11:0]               z_data,
  input  logic                      sample_valid,
  output logic                      meas_en,
  output logic                      cmd_err
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StRdata, StWdata, StIgnore} state_e;
  localparam int unsigned NumWr = 15;

  function automatic logic [7:0] wreg_default(input int unsigned idx);
    return (idx == 12) ? 8'h13 : 8'h00;
  endfunction

  // Front end: synchronizers plus one registered edge-detect stage.
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic sclk_s, cs_s;
  logic sclk_d_q, cs_d_q, rise_q, fall_q, cs_fall_q, cs_hi_q, mosi_q;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  // cs chain resets low so a cs_n held low across reset never looks like a new falling edge.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_d_q    <= 1'b0;
      cs_d_q      <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_hi_q     <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.cs_n};
      sclk_d_q    <= sclk_s;
      cs_d_q      <= cs_s;
      rise_q      <= sclk_s & ~sclk_d_q;
      fall_q      <= ~sclk_s & sclk_d_q;
      cs_fall_q   <= ~cs_s & cs_d_q;
      cs_hi_q     <= cs_s;
      mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
    end
  end

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [5:0]  ptr_q, ptr_d;
  logic        addr_bad_q, addr_bad_d;
  logic        is_read_q, is_read_d;
  logic        load_pend_q, load_pend_d;
  logic [7:0]  out_q, out_d;
  logic        cmd_err_q, cmd_err_d;
  logic        data_ready_q, data_ready_d;
  logic [7:0]  wreg_q [NumWr];
  logic [7:0]  wreg_d [NumWr];
  logic [11:0] x_q, y_q, z_q;
  logic [11:0] x_rd, y_rd, z_rd;
  logic [7:0]  byte_in, rd_byte;
  logic        byte_done, data_addr, wr_in_range, dr_clr;

`ifdef ACL_RESP_SNAPSHOT_EN
  logic [11:0] x_snap_q, y_snap_q, z_snap_q;

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      x_snap_q <= '0;
      y_snap_q <= '0;
      z_snap_q <= '0;
    end else if (cs_fall_q) begin
      x_snap_q <= x_q;
      y_snap_q <= y_q;
      z_snap_q <= z_q;
    end
  end

  assign x_rd = x_snap_q;
  assign y_rd = y_snap_q;
  assign z_rd = z_snap_q;
`else
  assign x_rd = x_q;
  assign y_rd = y_q;
  assign z_rd = z_q;
`endif

  assign meas_en     = (wreg_q[13][1:0] == 2'b10);
  assign cmd_err     = cmd_err_q;
  assign spi.miso    = (state_q == StRdata) & out_q[7];
  assign spi.miso_oe = (state_q == StRdata);
  assign byte_in     = {shift_q, mosi_q};
  assign byte_done   = rise_q && (bit_cnt_q == 3'd7);
  assign wr_in_range = (ptr_q[5:4] == 2'b10) && (ptr_q[3:0] != 4'hF);

  // Register map as seen by the pointer.
  always_comb begin
    rd_byte   = 8'h00;
    data_addr = ((ptr_q >= 6'h08) && (ptr_q <= 6'h0A)) || ((ptr_q >= 6'h0E) && (ptr_q <= 6'h13));
    case (ptr_q)
      6'h00:   rd_byte = 8'hAD;
      6'h01:   rd_byte = 8'h1D;
      6'h02:   rd_byte = PARTID;
      6'h03:   rd_byte = 8'h01;
      6'h08:   rd_byte = x_rd[11:4];
      6'h09:   rd_byte = y_rd[11:4];
      6'h0A:   rd_byte = z_rd[11:4];
      6'h0B:   rd_byte = {7'b0, data_ready_q};
      6'h0E:   rd_byte = x_rd[7:0];
      6'h0F:   rd_byte = {{4{x_rd[11]}}, x_rd[11:8]};
      6'h10:   rd_byte = y_rd[7:0];
      6'h11:   rd_byte = {{4{y_rd[11]}}, y_rd[11:8]};
      6'h12:   rd_byte = z_rd[7:0];
      6'h13:   rd_byte = {{4{z_rd[11]}}, z_rd[11:8]};
      default: if (wr_in_range) rd_byte = wreg_q[ptr_q[3:0]];
    endcase
    if (data_addr && !meas_en) rd_byte = 8'h00;
    if (addr_bad_q)            rd_byte = 8'h00;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    addr_bad_d  = addr_bad_q;
    is_read_d   = is_read_q;
    load_pend_d = load_pend_q;
    out_d       = out_q;
    cmd_err_d   = 1'b0;
    wreg_d      = wreg_q;
    dr_clr      = 1'b0;

    if (cs_hi_q) begin
      state_d     = StIdle;
      bit_cnt_d   = 3'd0;
      load_pend_d = 1'b0;
    end else if (cs_fall_q) begin
      state_d     = StCmd;
      bit_cnt_d   = 3'd0;
      load_pend_d = 1'b0;
      out_d       = 8'h00;
    end else if (state_q != StIdle) begin
      if (rise_q) begin
        shift_d   = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        case (state_q)
          StCmd: begin
            if (byte_in == 8'h0B) begin
              is_read_d = 1'b1;
              state_d   = StAddr;
            end else if (byte_in == 8'h0A) begin
              is_read_d = 1'b0;
              state_d   = StAddr;
            end else begin
              cmd_err_d = 1'b1;
              state_d   = StIgnore;
            end
          end
          StAddr: begin
            ptr_d       = byte_in[5:0];
            addr_bad_d  = |byte_in[7:6];
            state_d     = is_read_q ? StRdata : StWdata;
            load_pend_d = is_read_q;
          end
          StWdata: begin
            if (!addr_bad_q) begin
              if (wr_in_range) begin
                wreg_d[ptr_q[3:0]] = byte_in;
              end else if ((ptr_q == 6'h1F) && (byte_in == 8'h52)) begin
                for (int unsigned i = 0; i < NumWr; i++) wreg_d[i] = wreg_default(i);
              end
            end
            ptr_d = ptr_q + 6'd1;
          end
          StRdata: load_pend_d = 1'b1;
          default: ;
        endcase
      end
      // First falling edge after a byte boundary loads the next byte; the rest shift it out.
      if (fall_q && (state_q == StRdata)) begin
        if (load_pend_q) begin
          out_d       = rd_byte;
          ptr_d       = ptr_q + 6'd1;
          load_pend_d = 1'b0;
          dr_clr      = data_addr && !addr_bad_q;
        end else begin
          out_d = {out_q[6:0], 1'b0};
        end
      end
    end

    data_ready_d = data_ready_q;
    if (dr_clr)                  data_ready_d = 1'b0;
    if (sample_valid && meas_en) data_ready_d = 1'b1;
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      shift_q      <= '0;
      ptr_q        <= '0;
      addr_bad_q   <= 1'b0;
      is_read_q    <= 1'b0;
      load_pend_q  <= 1'b0;
      out_q        <= 8'h00;
      cmd_err_q    <= 1'b0;
      data_ready_q <= 1'b0;
      for (int unsigned i = 0; i < NumWr; i++) wreg_q[i] <= wreg_default(i);
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      addr_bad_q   <= addr_bad_d;
      is_read_q    <= is_read_d;
      load_pend_q  <= load_pend_d;
      out_q        <= out_d;
      cmd_err_q    <= cmd_err_d;
      data_ready_q <= data_ready_d;
      wreg_q       <= wreg_d;
    end
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (sample_valid) begin
      x_q <= x_data;
      y_q <= y_data;
      z_q <= z_data;
    end
  end

endmodule

// File: tb/tb_acl_spi_responder.sv
// Self-checking bench for acl_spi_responder: constant-map table, directed corner sequences,
// and randomized transactions scored against a register-map model of the device.
`timescale 1ns/1ps
module tb_acl_spi_responder;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acl_spi_responder_if spi ();
  logic [11:0] x_data, y_data, z_data;
  logic        sample_valid, meas_en, cmd_err;

  acl_spi_responder #(.SYNC_STAGES(2), .PARTID(8'hF2)) dut (
    .ClkPort      (clk),
    .Reset_n      (rst_n),
    .spi          (spi),
    .x_data       (x_data),
    .y_data       (y_data),
    .z_data       (z_data),
    .sample_valid (sample_valid),
    .meas_en      (meas_en),
    .cmd_err      (cmd_err)
  );

  int n_pass = 0;
  int n_total = 0;
  int err_cnt = 0;

  always @(negedge clk) if (rst_n && cmd_err) err_cnt++;

  // Device model: writable bytes, live samples, DATA_READY.
  logic [7:0] m_wr [64];
  int         m_s [3];
  bit         m_dr;
  bit         hdr_oe_any, data_oe_all;

  function automatic bit m_meas();
    return m_wr[8'h2D][1:0] == 2'b10;
  endfunction

  function automatic bit m_is_data(input int a);
    return (a >= 8 && a <= 10) || (a >= 14 && a <= 19);
  endfunction

  function automatic logic [7:0] m_reg(input int a);
    logic [15:0] w;
    int axis;
    if (a == 0) return 8'hAD;
    if (a == 1) return 8'h1D;
    if (a == 2) return 8'hF2;
    if (a == 3) return 8'h01;
    if (a == 11) return {7'b0, m_dr};
    if (a >= 32 && a <= 46) return m_wr[a];
    if (!m_is_data(a) || !m_meas()) return 8'h00;
    axis = (a <= 10) ? a - 8 : (a - 14) / 2;
    w = 16'(m_s[axis]);
    if (a <= 10) return 8'((m_s[axis] >>> 4) & 255);
    return ((a - 14) % 2 == 0) ? w[7:0] : w[15:8];
  endfunction

  task automatic m_soft_reset();
    for (int i = 0; i < 64; i++) m_wr[i] = (i == 8'h2C) ? 8'h13 : 8'h00;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                          output bit oe_any, output bit oe_all);
    rx = 8'h00;
    oe_any = 1'b0;
    oe_all = 1'b1;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi.mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = spi.miso;
      oe_any |= spi.miso_oe;
      oe_all &= spi.miso_oe;
      spi.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic cs_start();
    spi.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    spi.cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] rx;
    bit a, b;
    cs_start();
    spi_xfer(8'h0A, 8, rx, a, b);
    spi_xfer(addr, 8, rx, a, b);
    spi_xfer(data, 8, rx, a, b);
    cs_end();
    if (addr[7:6] == 2'b00) begin
      if (addr >= 8'h20 && addr <= 8'h2E) m_wr[addr] = data;
      else if (addr == 8'h1F && data == 8'h52) m_soft_reset();
    end
  endtask

  task automatic read1(input logic [7:0] addr, output logic [7:0] rx);
    bit a, b;
    cs_start();
    spi_xfer(8'h0B, 8, rx, a, b);
    spi_xfer(addr, 8, rx, a, b);
    spi_xfer(8'h00, 8, rx, a, b);
    cs_end();
  endtask

  // Burst read scored against the model; the trailing falling edge prefetches one more byte.
  task automatic read_burst(input logic [7:0] addr, input int n, input string name);
    logic [7:0] rx;
    bit a0, a1, b0, b1;
    bit bad;
    int a;
    bad = (addr[7:6] != 2'b00);
    cs_start();
    spi_xfer(8'h0B, 8, rx, a0, b0);
    spi_xfer(addr, 8, rx, a1, b1);
    hdr_oe_any = a0 | a1;
    data_oe_all = 1'b1;
    for (int k = 0; k <= n; k++) begin
      a = (int'(addr[5:0]) + k) % 64;
      if (k < n) begin
        spi_xfer(8'h00, 8, rx, a0, b0);
        data_oe_all &= b0;
        check($sformatf("%s[%0d]@%0h", name, k, a), rx, bad ? 8'h00 : m_reg(a));
      end
      if (!bad && m_is_data(a)) m_dr = 1'b0;
    end
    cs_end();
  endtask

  task automatic pulse_sample(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    x_data = x;
    y_data = y;
    z_data = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    m_s[0] = (x >= 2048) ? int'(x) - 4096 : int'(x);
    m_s[1] = (y >= 2048) ? int'(y) - 4096 : int'(y);
    m_s[2] = (z >= 2048) ? int'(z) - 4096 : int'(z);
    if (m_meas()) m_dr = 1'b1;
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t tbl [10];
    logic [7:0] rx, rx_a, rx2;
    bit oa, ob, oa2, ob2;
    int e0;
    logic [7:0] snap_exp;

    tbl[0] = '{8'h00, 8'hAD};  tbl[1] = '{8'h01, 8'h1D};
    tbl[2] = '{8'h02, 8'hF2};  tbl[3] = '{8'h03, 8'h01};
    tbl[4] = '{8'h2C, 8'h13};  tbl[5] = '{8'h2D, 8'h00};
    tbl[6] = '{8'h0B, 8'h00};  tbl[7] = '{8'h42, 8'h00};
    tbl[8] = '{8'h3F, 8'h00};  tbl[9] = '{8'h1F, 8'h00};

    spi.cs_n = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    x_data = '0;
    y_data = '0;
    z_data = '0;
    sample_valid = 1'b0;
    m_soft_reset();
    m_s[0] = 0; m_s[1] = 0; m_s[2] = 0;
    m_dr = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_miso", spi.miso, 1'b0);
    check("reset_miso_oe", spi.miso_oe, 1'b0);
    check("reset_meas_en", meas_en, 1'b0);
    check("reset_cmd_err", cmd_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      read1(tbl[i].addr, rx);
      check($sformatf("table@%0h", tbl[i].addr), rx, tbl[i].exp);
    end

    read_burst(8'h00, 4, "id");
    check("id_hdr_oe", hdr_oe_any, 1'b0);
    check("id_data_oe", data_oe_all, 1'b1);
    check("idle_miso_oe", spi.miso_oe, 1'b0);

    write_reg(8'h2D, 8'h02);
    check("meas_on", meas_en, 1'b1);
    pulse_sample(12'h7FF, 12'h800, 12'h001);
    read_burst(8'h0B, 1, "status_set");
    read_burst(8'h0E, 6, "meas");
    read_burst(8'h0B, 1, "status_clr");

    // Sample update lands during the address byte of a read at 0x08.
    pulse_sample(12'h100, 12'h000, 12'h000);
    cs_start();
    spi_xfer(8'h0B, 8, rx, oa, ob);
    fork
      spi_xfer(8'h08, 8, rx_a, oa2, ob2);
      begin
        repeat (4 * HALF) @(negedge clk);
        pulse_sample(12'h7F0, 12'h000, 12'h000);
      end
    join
    spi_xfer(8'h00, 8, rx, oa, ob);
    cs_end();
`ifdef ACL_RESP_SNAPSHOT_EN
    snap_exp = 8'h10;
`else
    snap_exp = 8'h7F;
`endif
    check("snapshot", rx, snap_exp);
    m_dr = 1'b0;

    e0 = err_cnt;
    cs_start();
    spi_xfer(8'h55, 8, rx, oa, ob);
    spi_xfer(8'hA5, 8, rx, oa, ob);
    spi_xfer(8'hFF, 8, rx2, oa2, ob2);
    cs_end();
    check("badcmd_pulses", err_cnt - e0, 1);
    check("badcmd_miso", {rx, rx2}, 16'h0000);
    check("badcmd_oe", oa | oa2, 1'b0);
    read_burst(8'h2D, 1, "badcmd_power");

    write_reg(8'h2D, 8'h00);
    cs_start();
    spi_xfer(8'h0A, 8, rx, oa, ob);
    spi_xfer(8'h2D, 8, rx, oa, ob);
    spi_xfer(8'h02, 4, rx, oa, ob);
    cs_end();
    check("abort_meas", meas_en, 1'b0);
    read_burst(8'h2D, 1, "abort_power");
    read_burst(8'h00, 1, "abort_id");

    write_reg(8'h2D, 8'h02);
    write_reg(8'h2C, 8'h55);
    check("pre_softrst_meas", meas_en, 1'b1);
    write_reg(8'h1F, 8'h52);
    check("softrst_meas", meas_en, 1'b0);
    read_burst(8'h2C, 1, "softrst_filter");
    read_burst(8'h08, 1, "softrst_x");

    for (int it = 0; it < 40; it++) begin
      int op;
      logic [7:0] ad;
      op = $urandom_range(0, 3);
      if (op == 0) begin
        ad = 8'($urandom_range(8'h1C, 8'h31));
        if ($urandom_range(0, 1) == 1) write_reg(8'h2D, 8'h02);
        else write_reg(ad, (ad == 8'h1F && $urandom_range(0, 1) == 1) ? 8'h52 : 8'($urandom));
      end else if (op == 1) begin
        ad = 8'($urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0) ad[7:6] = 2'($urandom_range(1, 3));
        read_burst(ad, $urandom_range(1, 3), "rand");
      end else begin
        pulse_sample(12'($urandom), 12'($urandom), 12'($urandom));
        read_burst(8'($urandom_range(8, 19)), $urandom_range(1, 3), "rand_data");
      end
      check("rand_meas_en", meas_en, m_meas());
    end

    check("total_cmd_err", err_cnt, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
